// File: rtl/rr_arb_mux_if.sv
// Valid/ready bundle for rr_arb_mux: N input streams in, one registered stream out.
// The master side drives inputs and out_rdy; the arbiter is the slave.
interface rr_arb_mux_if #(
  parameter int p_nbits     = 32,
  parameter int p_nchannels = 4
);
  localparam int p_sw = (p_nchannels > 1) ? $clog2(p_nchannels) : 1;

  logic [p_nchannels-1:0]         in_val;
  logic [p_nchannels-1:0]         in_rdy;
  logic [p_nchannels*p_nbits-1:0] in_msg;
  logic                           out_val;
  logic                           out_rdy;
  logic [p_nbits-1:0]             out_msg;
  logic [p_sw-1:0]                out_sel;

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_sel
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N-way valid/ready multiplexer with round-robin or fixed-priority
// arbitration; reports the source channel alongside the message.
module rr_arb_mux #(
  parameter int p_nbits     = 32,
  parameter int p_nchannels = 4,
  parameter int p_rr        = 1
) (
  input  logic         clk,
  input  logic         reset,
  rr_arb_mux_if.slave  bus
);
  localparam int p_sw = (p_nchannels > 1) ? $clog2(p_nchannels) : 1;

  logic [p_nbits-1:0]     out_msg_reg;
  logic [p_sw-1:0]        out_sel_reg;
  logic                   out_val_reg;
  logic [p_sw-1:0]        ptr_reg;
  logic [p_sw-1:0]        ptr_next;

  logic                   space;
  logic                   grant_any;
  logic [p_sw-1:0]        grant_idx;
  logic [p_nchannels-1:0] grant_oh;
  logic [p_nbits-1:0]     masked_msg [p_nchannels];
  logic [p_nbits-1:0]     grant_msg;
  logic                   accept;

  assign space  = !out_val_reg || bus.out_rdy;
  assign accept = grant_any && space;

  // Scan downward so the candidate closest to the scan start wins last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = p_nchannels - 1; k >= 0; k--) begin
      int cand;
      cand = (p_rr != 0) ? int'(ptr_reg) + k : k;
      if (cand >= p_nchannels) cand = cand - p_nchannels;
      if (bus.in_val[cand]) begin
        grant_any = 1'b1;
        grant_idx = p_sw'(cand);
      end
    end
  end

  // AND-OR mux keeps unselected (possibly X) slices out of out_msg.
  generate
    for (genvar gi = 0; gi < p_nchannels; gi++) begin : g_chan
      assign grant_oh[gi]   = grant_any && (grant_idx == p_sw'(gi));
      assign masked_msg[gi] = bus.in_msg[gi*p_nbits +: p_nbits] & {p_nbits{grant_oh[gi]}};
    end
  endgenerate

  always_comb begin
    grant_msg = '0;
    for (int k = 0; k < p_nchannels; k++) begin
      grant_msg = grant_msg | masked_msg[k];
    end
  end

  assign ptr_next = (grant_idx == p_sw'(p_nchannels - 1)) ? '0 : grant_idx + p_sw'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_val_reg <= 1'b0;
      out_msg_reg <= '0;
      out_sel_reg <= '0;
      ptr_reg     <= '0;
    end else if (accept) begin
      out_val_reg <= 1'b1;
      out_msg_reg <= grant_msg;
      out_sel_reg <= grant_idx;
      if (p_rr != 0) ptr_reg <= ptr_next;
    end else if (bus.out_rdy) begin
      out_val_reg <= 1'b0;
    end
  end

  assign bus.in_rdy  = (reset && space) ? grant_oh : '0;
  assign bus.out_val = out_val_reg;
  assign bus.out_msg = out_msg_reg;
  assign bus.out_sel = out_sel_reg;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (4ch round-robin, 4ch fixed, 3ch round-robin)
// checked every cycle against a queue-free behavioural model plus directed expectations.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.p_nbits(32), .p_nchannels(4)) if_a();
  rr_arb_mux_if #(.p_nbits(32), .p_nchannels(4)) if_b();
  rr_arb_mux_if #(.p_nbits(32), .p_nchannels(3)) if_c();

  rr_arb_mux #(.p_nbits(32), .p_nchannels(4), .p_rr(1)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  rr_arb_mux #(.p_nbits(32), .p_nchannels(4), .p_rr(0)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  rr_arb_mux #(.p_nbits(32), .p_nchannels(3), .p_rr(1)) u_c (.clk(clk), .reset(reset), .bus(if_c));

  logic [3:0]  drv_val [3];
  logic [31:0] drv_msg [3][4];
  logic        drv_rdy [3];

  assign if_a.in_val  = drv_val[0];
  assign if_a.in_msg  = {drv_msg[0][3], drv_msg[0][2], drv_msg[0][1], drv_msg[0][0]};
  assign if_a.out_rdy = drv_rdy[0];
  assign if_b.in_val  = drv_val[1];
  assign if_b.in_msg  = {drv_msg[1][3], drv_msg[1][2], drv_msg[1][1], drv_msg[1][0]};
  assign if_b.out_rdy = drv_rdy[1];
  assign if_c.in_val  = drv_val[2][2:0];
  assign if_c.in_msg  = {drv_msg[2][2], drv_msg[2][1], drv_msg[2][0]};
  assign if_c.out_rdy = drv_rdy[2];

  int n_ch [3] = '{4, 4, 3};
  int is_rr [3] = '{1, 0, 1};

  bit          m_val [3];
  logic [31:0] m_msg [3];
  int          m_sel [3];
  int          m_ptr [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_grant(input int n, input int rr, input int ptr, input logic [3:0] v);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (rr != 0) ? (ptr + k) % n : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check in_rdy before the edge, advance the model, check outputs after.
  task automatic step(input string tag);
    logic [31:0] act_rdy [3];
    logic [31:0] act_val [3];
    logic [31:0] act_msg [3];
    logic [31:0] act_sel [3];
    int g [3];
    #1;
    act_rdy[0] = 32'(if_a.in_rdy);
    act_rdy[1] = 32'(if_b.in_rdy);
    act_rdy[2] = 32'(if_c.in_rdy);
    for (int d = 0; d < 3; d++) begin
      logic [31:0] exp_rdy;
      g[d] = ref_grant(n_ch[d], is_rr[d], m_ptr[d], drv_val[d]);
      exp_rdy = (reset && (!m_val[d] || drv_rdy[d]) && g[d] >= 0) ? (32'd1 << g[d]) : 32'd0;
      chk($sformatf("%s dut%0d in_rdy", tag, d), act_rdy[d], exp_rdy);
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!reset) begin
        m_val[d] = 1'b0; m_msg[d] = '0; m_sel[d] = 0; m_ptr[d] = 0;
      end else if ((!m_val[d] || drv_rdy[d]) && g[d] >= 0) begin
        m_val[d] = 1'b1;
        m_msg[d] = drv_msg[d][g[d]];
        m_sel[d] = g[d];
        if (is_rr[d] != 0) m_ptr[d] = (g[d] + 1) % n_ch[d];
      end else if (m_val[d] && drv_rdy[d]) begin
        m_val[d] = 1'b0;
      end
    end
    #1;
    act_val[0] = 32'(if_a.out_val); act_msg[0] = if_a.out_msg; act_sel[0] = 32'(if_a.out_sel);
    act_val[1] = 32'(if_b.out_val); act_msg[1] = if_b.out_msg; act_sel[1] = 32'(if_b.out_sel);
    act_val[2] = 32'(if_c.out_val); act_msg[2] = if_c.out_msg; act_sel[2] = 32'(if_c.out_sel);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s dut%0d out_val", tag, d), act_val[d], 32'(m_val[d]));
      chk($sformatf("%s dut%0d out_msg", tag, d), act_msg[d], m_msg[d]);
      chk($sformatf("%s dut%0d out_sel", tag, d), act_sel[d], 32'(m_sel[d]));
    end
    $display("[%0t] %s a:v%0d s%0d m%h b:v%0d s%0d m%h c:v%0d s%0d m%h", $time, tag,
             if_a.out_val, if_a.out_sel, if_a.out_msg, if_b.out_val, if_b.out_sel, if_b.out_msg,
             if_c.out_val, if_c.out_sel, if_c.out_msg);
  endtask

  task automatic set_all(input logic [3:0] v, input logic r);
    for (int d = 0; d < 3; d++) begin
      drv_val[d] = v;
      drv_rdy[d] = r;
    end
  endtask

  task automatic set_msgs_base(input logic [31:0] base);
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) drv_msg[d][i] = base + 32'(i);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_val[d] = 1'b0; m_msg[d] = '0; m_sel[d] = 0; m_ptr[d] = 0;
    end
    set_msgs_base(32'd0);
    @(negedge clk);

    // Reset with all inputs valid.
    reset = 1'b0;
    set_all(4'b1111, 1'b1);
    step("rst0");
    chk("rst in_rdy a", 32'(if_a.in_rdy), 32'd0);
    step("rst1");
    chk("rst out_val a", 32'(if_a.out_val), 32'd0);
    chk("rst out_msg a", if_a.out_msg, 32'd0);
    reset = 1'b1;
    set_all(4'b0000, 1'b1);
    step("idle");
    chk("idle out_val a", 32'(if_a.out_val), 32'd0);

    // Single transfer from channel 2.
    set_all(4'b0100, 1'b1);
    drv_msg[0][2] = 32'hDEADBEEF;
    #1;
    chk("single in_rdy", 32'(if_a.in_rdy), 32'h4);
    step("single");
    chk("single out_msg", if_a.out_msg, 32'hDEADBEEF);
    chk("single out_sel", 32'(if_a.out_sel), 32'd2);
    set_all(4'b0000, 1'b1);
    step("drain");
    chk("drain out_val", 32'(if_a.out_val), 32'd0);
    chk("drain hold msg", if_a.out_msg, 32'hDEADBEEF);

    // Round-robin rotation from a fresh pointer.
    reset = 1'b0;
    step("rst2");
    reset = 1'b1;
    set_msgs_base(32'd100);
    set_all(4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step("rot");
      chk("rot a sel", 32'(if_a.out_sel), 32'(k % 4));
      chk("rot a msg", if_a.out_msg, 32'(100 + k % 4));
      chk("rot a val", 32'(if_a.out_val), 32'd1);
      chk("rot c sel", 32'(if_c.out_sel), 32'(k % 3));
      chk("rot b sel", 32'(if_b.out_sel), 32'd0);
    end

    // Back-pressure: load 100 with ptr=1, then stall.
    reset = 1'b0;
    step("rst3");
    reset = 1'b1;
    set_all(4'b1111, 1'b1);
    step("load");
    chk("load msg", if_a.out_msg, 32'd100);
    set_all(4'b0011, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("stall");
      chk("stall in_rdy", 32'(if_a.in_rdy), 32'd0);
      chk("stall msg", if_a.out_msg, 32'd100);
      chk("stall sel", 32'(if_a.out_sel), 32'd0);
    end
    set_all(4'b0011, 1'b1);
    #1;
    chk("release in_rdy", 32'(if_a.in_rdy), 32'h2);
    step("release");
    chk("release msg", if_a.out_msg, 32'd101);

    // Fixed priority: channel 1 dominates channel 3.
    set_all(4'b1010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step("fixed");
      chk("fixed sel", 32'(if_b.out_sel), 32'd1);
    end
    set_all(4'b1000, 1'b1);
    step("fixed3");
    chk("fixed3 sel", 32'(if_b.out_sel), 32'd3);
    chk("fixed3 msg", if_b.out_msg, 32'd103);

    // Three-channel wrap.
    reset = 1'b0;
    step("rst4");
    reset = 1'b1;
    set_all(4'b0111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step("wrap");
      chk("wrap c sel", 32'(if_c.out_sel), 32'(k % 3));
    end

    // Random traffic, with one reset in the middle.
    for (int k = 0; k < 50; k++) begin
      reset = (k == 25) ? 1'b0 : 1'b1;
      for (int d = 0; d < 3; d++) begin
        drv_val[d] = 4'($urandom_range(0, 15));
        drv_rdy[d] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) drv_msg[d][i] = $urandom;
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
